// File: rtl/dbx_symbol_coder.sv
// Encoder-side symbol coder: maps delta bit-plane words to left-aligned variable-length
// codewords and merges runs of all-zero words into run-length symbols.
module dbx_symbol_coder #(
    parameter int unsigned MAX_ZRL = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] dbx_i,
    input  logic       is_dbp_i,
    input  logic       last_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic [2:0] len_o,
    output logic       last_o,
    output logic       valid_o,
    input  logic       ready_i
);

    localparam logic [2:0] LEN_EMPTY           = 3'd0;
    localparam logic [2:0] LEN_TWO             = 3'd1;
    localparam logic [2:0] LEN_THREE_PLUS_LOGM = 3'd2;
    localparam logic [2:0] LEN_FIVE            = 3'd3;
    localparam logic [2:0] LEN_FIVE_PLUS_LOGN  = 3'd4;
    localparam logic [2:0] LEN_N               = 3'd5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    // Returns {len, codeword} for a non-zero or DBP beat.
    function automatic logic [10:0] beat_code(input logic [6:0] dbx, input logic is_dbp);
        logic [2:0] p;
        logic [2:0] ones;
        logic [2:0] idx;
        logic [10:0] code;
        p    = 3'd0;
        ones = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (dbx[i]) begin
                p    = 3'(i);
                ones = ones + 3'd1;
            end
        end
        idx = 3'd6 - p;
        if (is_dbp) begin
            code = {LEN_FIVE, 8'b0000_1000};
        end else if (&dbx) begin
            code = {LEN_FIVE, 8'h00};
        end else if (ones == 3'd1) begin
            code = {LEN_FIVE_PLUS_LOGN, 5'b00011, idx};
        end else if (ones == 3'd2 && p != 3'd0 && dbx[p - 3'd1]) begin
            code = {LEN_FIVE_PLUS_LOGN, 5'b00010, idx};
        end else begin
            code = {LEN_N, 1'b1, dbx};
        end
        return code;
    endfunction

    // Returns {len, codeword} for a zero run of length k (k >= 1).
    function automatic logic [10:0] run_code(input logic [3:0] k);
        logic [2:0] km1;
        logic [10:0] code;
        km1 = 3'(k - 4'd1);
        if (k == 4'd1) begin
            code = {LEN_TWO, 8'b0100_0000};
        end else begin
            code = {LEN_THREE_PLUS_LOGM, 3'b001, km1, 2'b00};
        end
        return code;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  zc_q, zc_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  len_q, len_d;
    logic        last_q, last_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [2:0]  pend_len_q, pend_len_d;
    logic        pend_last_q, pend_last_d;

    logic        accept;
    logic        zero_beat;
    logic [3:0]  zc_inc;
    logic [10:0] beat_sym;
    logic [10:0] run_inc_sym;
    logic [10:0] run_cur_sym;

    assign ready_o     = rst_ni && (state_q != PEND) && (!valid_q || ready_i);
    assign accept      = valid_i && ready_o;
    assign zero_beat   = (dbx_i == 7'd0) && !is_dbp_i;
    assign zc_inc      = zc_q + 4'd1;
    assign beat_sym    = beat_code(dbx_i, is_dbp_i);
    assign run_inc_sym = run_code(zc_inc);
    assign run_cur_sym = run_code(zc_q);

    always_comb begin
        state_d     = state_q;
        zc_d        = zc_q;
        valid_d     = valid_q;
        data_d      = data_q;
        len_d       = len_q;
        last_d      = last_q;
        pend_data_d = pend_data_q;
        pend_len_d  = pend_len_q;
        pend_last_d = pend_last_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // PEND only leaves when the run symbol ahead of the held beat has been taken.
        if (state_q == PEND) begin
            if (valid_q && ready_i) begin
                valid_d = 1'b1;
                data_d  = pend_data_q;
                len_d   = pend_len_q;
                last_d  = pend_last_q;
                state_d = IDLE;
            end
        end else if (accept) begin
            if (zero_beat) begin
                if (zc_inc == 4'(MAX_ZRL) || last_i) begin
                    valid_d = 1'b1;
                    {len_d, data_d} = run_inc_sym;
                    last_d  = last_i;
                    zc_d    = 4'd0;
                    state_d = IDLE;
                end else begin
                    zc_d    = zc_inc;
                    state_d = RUN;
                end
            end else if (state_q == IDLE) begin
                valid_d = 1'b1;
                {len_d, data_d} = beat_sym;
                last_d  = last_i;
            end else begin
                valid_d = 1'b1;
                {len_d, data_d} = run_cur_sym;
                last_d  = 1'b0;
                {pend_len_d, pend_data_d} = beat_sym;
                pend_last_d = last_i;
                zc_d    = 4'd0;
                state_d = PEND;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            zc_q        <= 4'd0;
            valid_q     <= 1'b0;
            data_q      <= 8'd0;
            len_q       <= LEN_N;
            last_q      <= 1'b0;
            pend_data_q <= 8'd0;
            pend_len_q  <= LEN_EMPTY;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zc_q        <= zc_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            len_q       <= len_d;
            last_q      <= last_d;
            pend_data_q <= pend_data_d;
            pend_len_q  <= pend_len_d;
            pend_last_q <= pend_last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign len_o   = len_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_dbx_symbol_coder.sv
// Directed bench for dbx_symbol_coder: hand-computed codewords, run merging,
// back-pressure while a symbol is held, and mid-run reset.
module tb_dbx_symbol_coder;

    localparam logic [2:0] LEN_TWO             = 3'd1;
    localparam logic [2:0] LEN_THREE_PLUS_LOGM = 3'd2;
    localparam logic [2:0] LEN_FIVE            = 3'd3;
    localparam logic [2:0] LEN_FIVE_PLUS_LOGN  = 3'd4;
    localparam logic [2:0] LEN_N               = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] dbx;
    logic       is_dbp;
    logic       last_in;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] data_out;
    logic [2:0] len_out;
    logic       last_out;
    logic       valid_out;
    logic       ready_in;

    int checks   = 0;
    int failures = 0;

    logic [7:0] obsData[$];
    logic [2:0] obsLen[$];
    logic       obsLast[$];

    always #5 clk = ~clk;

    dbx_symbol_coder #(.MAX_ZRL(8)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .dbx_i    (dbx),
        .is_dbp_i (is_dbp),
        .last_i   (last_in),
        .valid_i  (valid_in),
        .ready_o  (ready_out),
        .data_o   (data_out),
        .len_o    (len_out),
        .last_o   (last_out),
        .valid_o  (valid_out),
        .ready_i  (ready_in)
    );

    // Inputs only change 1ns after posedge, so negedge values describe the coming transfer.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_in) begin
            obsData.push_back(data_out);
            obsLen.push_back(len_out);
            obsLast.push_back(last_out);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] d, input logic dbp, input logic lst);
        logic rdy;
        logic accepted;
        dbx      = d;
        is_dbp   = dbp;
        last_in  = lst;
        valid_in = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 30 && !accepted; i++) begin
            @(negedge clk);
            rdy = ready_out;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
        end
        valid_in = 1'b0;
        dbx      = 7'd0;
        is_dbp   = 1'b0;
        last_in  = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout observed=not_accepted expected=accepted");
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expData, input logic [2:0] expLen,
                               input logic expLast);
        for (int i = 0; i < 40 && obsData.size() == 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (obsData.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s observed=no_symbol expected=%0h", tag, expData);
        end else begin
            checkVal({tag, "_data"}, 32'(obsData.pop_front()), 32'(expData));
            checkVal({tag, "_len"},  32'(obsLen.pop_front()),  32'(expLen));
            checkVal({tag, "_last"}, 32'(obsLast.pop_front()), 32'(expLast));
        end
    endtask

    task automatic checkIdle(input string tag);
        repeat (4) @(posedge clk);
        #1;
        checkVal(tag, 32'(obsData.size()), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ready_in = 1'b1;
        valid_in = 1'b0;
        dbx      = 7'd0;
        is_dbp   = 1'b0;
        last_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst_valid", 32'(valid_out), 32'd0);
        checkVal("rst_data",  32'(data_out),  32'd0);
        checkVal("rst_len",   32'(len_out),   32'(LEN_N));
        checkVal("rst_last",  32'(last_out),  32'd0);
        checkVal("rst_ready", 32'(ready_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] test 1: single zero then literal with last");
        applyStimulus(7'b0000000, 1'b0, 1'b0);
        applyStimulus(7'b1010101, 1'b0, 1'b1);
        @(negedge clk);
        checkVal("t1_ready_pend", 32'(ready_out), 32'd0);
        @(negedge clk);
        checkVal("t1_ready_back", 32'(ready_out), 32'd1);
        checkOutput("t1_run1", 8'h40, LEN_TWO, 1'b0);
        checkOutput("t1_lit",  8'hD5, LEN_N,   1'b1);
        checkIdle("t1_extra");

        $display("[TB] test 2: run of three then single bit");
        repeat (3) applyStimulus(7'b0000000, 1'b0, 1'b0);
        applyStimulus(7'b1000000, 1'b0, 1'b1);
        checkOutput("t2_run3", 8'h28, LEN_THREE_PLUS_LOGM, 1'b0);
        checkOutput("t2_bit6", 8'h18, LEN_FIVE_PLUS_LOGN,  1'b1);
        checkIdle("t2_extra");

        $display("[TB] test 3: nine zeros split at the maximum run");
        for (int i = 0; i < 9; i++) applyStimulus(7'b0000000, 1'b0, i == 8);
        checkOutput("t3_run8", 8'h3C, LEN_THREE_PLUS_LOGM, 1'b0);
        checkOutput("t3_run1", 8'h40, LEN_TWO,             1'b1);
        checkIdle("t3_extra");

        $display("[TB] test 4: code map");
        applyStimulus(7'b1111111, 1'b0, 1'b0);
        applyStimulus(7'b0000000, 1'b1, 1'b0);
        applyStimulus(7'b0011000, 1'b0, 1'b0);
        applyStimulus(7'b0110001, 1'b0, 1'b1);
        checkOutput("t4_ones", 8'h00, LEN_FIVE,           1'b0);
        checkOutput("t4_dbp",  8'h08, LEN_FIVE,           1'b0);
        checkOutput("t4_pair", 8'h12, LEN_FIVE_PLUS_LOGN, 1'b0);
        checkOutput("t4_lit",  8'hB1, LEN_N,              1'b1);
        checkIdle("t4_extra");

        $display("[TB] test 5: stall while a symbol is pending");
        ready_in = 1'b0;
        applyStimulus(7'b0000000, 1'b0, 1'b0);
        applyStimulus(7'b0000001, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal("t5_hold_valid", 32'(valid_out), 32'd1);
            checkVal("t5_hold_data",  32'(data_out),  32'h40);
            checkVal("t5_hold_ready", 32'(ready_out), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        checkOutput("t5_run1", 8'h40, LEN_TWO,            1'b0);
        checkOutput("t5_bit0", 8'h1E, LEN_FIVE_PLUS_LOGN, 1'b1);
        checkIdle("t5_extra");

        $display("[TB] test 6: reset in the middle of a run");
        applyStimulus(7'b0000000, 1'b0, 1'b0);
        applyStimulus(7'b0000000, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkVal("t6_rst_ready", 32'(ready_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(7'b1000000, 1'b0, 1'b1);
        checkOutput("t6_bit6", 8'h18, LEN_FIVE_PLUS_LOGN, 1'b1);
        checkIdle("t6_extra");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
